// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2
  } life_state_t;

  // Eight neighbours need a count up to 8, hence four bits.
  localparam int NBR_W = 4;

  function automatic int cell_index(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: survive on 2 or 3 neighbours, birth on exactly 3.
module life_cell_rule
  import life_pkg::*;
(
  input  logic       self,
  input  logic [7:0] nbrs,
  output logic       next
);

  logic [NBR_W-1:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {{(NBR_W-1){1'b0}}, nbrs[i]};
    end
    next = (count == NBR_W'(3)) || (self && (count == NBR_W'(2)));
  end

endmodule

// File: rtl/life_grid_engine.sv
// Parametrised Game-of-Life engine: serial load, one generation per clock,
// early stop on fixed point or extinction, serial dump with valid/ready.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic             load_bit,
  output logic             load_ready,
  input  logic             start,
  input  logic [GEN_W-1:0] steps,
  input  logic             wrap_en,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gens_done,
  output logic             stable,
  output logic             extinct,
  output logic [1:0]       state_dbg
);

  localparam int N     = ROWS * COLS;
  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  // Handshake rule for both streams: a beat transfers on the rising edge
  // where valid and ready are both high; valid never depends on ready.
  life_state_t      state_q, state_d;
  logic [N-1:0]     grid, grid_loaded, next_grid;
  logic [PTR_W-1:0] load_ptr, out_ptr;
  logic [GEN_W-1:0] steps_q, gens_done_q, gens_inc;
  logic             wrap_q, stable_q, extinct_q, done_q;
  logic             next_same, next_dead, grid_dead, loaded_dead, dump_last_hs;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbrs;
      for (genvar d = 0; d < 8; d++) begin : g_nbr
        // Walk the 3x3 window skipping the centre (window index 4).
        localparam int  E      = (d < 4) ? d : d + 1;
        localparam int  RR     = r + E / 3 - 1;
        localparam int  CC     = c + E % 3 - 1;
        localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
        localparam int  IDX    = cell_index((RR + ROWS) % ROWS, (CC + COLS) % COLS, COLS);
        assign nbrs[d] = (INSIDE || wrap_q) ? grid[IDX] : 1'b0;
      end
      life_cell_rule u_rule (
        .self (grid[cell_index(r, c, COLS)]),
        .nbrs (nbrs),
        .next (next_grid[cell_index(r, c, COLS)])
      );
    end
  end

  always_comb begin
    grid_loaded = grid;
    if (load_valid) grid_loaded[load_ptr] = load_bit;
  end

  assign gens_inc     = gens_done_q + GEN_W'(1);
  assign next_same    = (next_grid == grid);
  assign next_dead    = ~|next_grid;
  assign grid_dead    = ~|grid;
  assign loaded_dead  = ~|grid_loaded;
  assign dump_last_hs = (state_q == S_DUMP) && out_ready && (out_ptr == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (steps == '0) ? S_DUMP : S_RUN;
      S_RUN: begin
        if (next_same || next_dead || (gens_inc == steps_q)) state_d = S_DUMP;
      end
      S_DUMP: if (dump_last_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    out_valid  = (state_q == S_DUMP);
    out_bit    = out_valid && grid[out_ptr];
    out_last   = out_valid && (out_ptr == LAST);
    state_dbg  = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid        <= '0;
      load_ptr    <= '0;
      out_ptr     <= '0;
      steps_q     <= '0;
      wrap_q      <= 1'b0;
      gens_done_q <= '0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= dump_last_hs;
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            grid     <= grid_loaded;
            load_ptr <= (load_ptr == LAST) ? '0 : load_ptr + PTR_W'(1);
          end
          if (start) begin
            steps_q     <= steps;
            wrap_q      <= wrap_en;
            gens_done_q <= '0;
            stable_q    <= 1'b0;
            extinct_q   <= (steps == '0) && loaded_dead;
            load_ptr    <= '0;
          end
        end
        S_RUN: begin
          // A fixed point is detected before applying, so the grid is left as is.
          if (next_same) begin
            stable_q  <= 1'b1;
            extinct_q <= grid_dead;
          end else begin
            grid        <= next_grid;
            gens_done_q <= gens_inc;
            if (next_dead) extinct_q <= 1'b1;
          end
        end
        S_DUMP: begin
          if (out_ready) out_ptr <= (out_ptr == LAST) ? '0 : out_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign gens_done = gens_done_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule
